spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  Command sequencer between the byte-level SPI slave core and the board I/O (gpo_pins, led0, led1).
//  Decodes each SSB-framed transaction: a command byte, then data bytes with address auto-increment.
//  Executes reads and writes to a small register file and preloads MISO bytes for reads.
//  Owns the LED blink prescaler. Sits directly under the top level, fed by the SPI slave core.
// PARAMETERS
//  ID_VALUE   8'hA5       value returned by read-only register 0x00
//  BLINK_DIV  25_000_000  INPUT_CLK cycles per led0 blink toggle (>=2)
// PORTS
//  INPUT_CLK  in   1  the single clock; all logic rising-edge
//  reset      in   1  synchronous, active-high reset
//  ss_active  in   1  frame active (SSB low), already synchronised to INPUT_CLK
//  rx_valid   in   1  one-cycle pulse: rx_byte holds a complete received byte
//  rx_byte    in   8  received byte, MSB first on the wire
//  tx_load    out  1  one-cycle pulse: SPI core latches tx_byte for the next byte slot
//  tx_byte    out  8  byte to shift out on MISO
//  gpo_pins   out  7  register 0x01 [6:0]
//  led0       out  1  manual or blink, selected by register 0x02
//  led1       out  1  register 0x02 bit1
// BEHAVIOUR
//  Reset values: tx_load=0, tx_byte=8'h00, gpo_pins=0, led0=0, led1=0, all registers 0, FSM=IDLE, blink counter 0.
//  Register map (7-bit address): 0x00 ID (RO) | 0x01 GPO[6:0] (RW; bit7 reads 0) | 0x02 LEDCTL (RW):
//   bit0 led0 manual, bit1 led1, bit2 led0 blink enable; bits7:3 read 0 |
//   0x03 SCRATCH (RW, 8 bits) | 0x04 FRAMES (RO, 8-bit count of completed frames, wraps 0xFF->0x00) |
//   0x05 ERRS (RO, 8-bit saturating count of unmapped-address accesses).
//  Unmapped addresses (0x06-0x7F): reads return 8'h00; writes are discarded. Each access increments ERRS, saturating at 0xFF.
//  Command byte: bit7 = 1 read, 0 write; bits6:0 = start address.
//  FSM states: IDLE, CMD, WR, RD.
//   IDLE -> CMD on a rising edge of ss_active.
//   CMD: on rx_valid, latch addr and dir; go to WR or RD.
//    On a read, also start the preload for addr.
//   WR: each rx_valid writes rx_byte to addr, then addr <= addr+1.
//   RD: each rx_valid (master dummy byte) advances addr <= addr+1 and preloads the new addr.
//   Any state -> IDLE on ss_active low. FRAMES increments only if the frame reached WR or RD.
//  Address increment is 7-bit and wraps 0x7F -> 0x00.
//  Read preload timing: the rx_valid cycle registers the read data. tx_load pulses one cycle later, with tx_byte stable from that cycle until the next tx_load.
//   Fixed latency: rx_valid to tx_load = 1 cycle.
//  In WR and IDLE, tx_byte = 8'h00. No tx_load occurs except the preloads described above.
//  A register write takes effect on its outputs (gpo_pins/leds) on the cycle after rx_valid.
//  A read following a write to the same address in the same burst sees the new value.
//  ss_active deasserting on the same cycle as rx_valid: the byte is discarded (no write, no preload, no ERRS increment).
//   FRAMES still increments if the frame was already in WR or RD.
//  ss_active high again while still in IDLE on the following cycle starts a new frame normally. There is no inter-frame state other than registers and counters.
//  Blink: the counter runs only while LEDCTL bit2=1. It counts 0..BLINK_DIV-1, toggling the blink phase at wrap.
//   Clearing bit2 zeroes the counter and phase; led0 = bit2 ? phase : bit0.
//  reset mid-frame: aborts the frame immediately, restores all reset values, FSM=IDLE.
//   A frame in progress when reset releases is ignored until ss_active falls and rises again.
// TESTING
//  1 Write frame [0x01,0x55] -> gpo_pins=7'h55 one cycle after 2nd rx_valid; FRAMES=1; no tx_load pulses.
//  2 Read frame [0x80,0x00,0x00] -> tx_load 1 cycle after each rx_valid; tx_byte 0xA5 then 0x55 (addr 0x01) then 0x00 (LEDCTL).
//  3 Burst write [0x7F,0x11,0x22] -> 0x7F discarded, ERRS=1; addr wraps, 0x00 (RO ID) unchanged; read back ID=0xA5.
//  4 Write LEDCTL=0x04 with BLINK_DIV=4 -> led0 toggles every 4 cycles; write 0x01 -> led0=1 next cycle, counter 0.
//  5 ss_active falls on the same cycle as the 2nd rx_valid of [0x03,0x99] -> SCRATCH stays 0x00, FRAMES=1.
//  6 reset pulsed mid-write burst -> all outputs 0, FRAMES=0; bytes ignored until ss_active falls and rises again.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Command sequencer behind the byte-level SPI slave: decodes SSB-framed
// read/write bursts into a small register file and drives GPO and LED pins.
module spi_reg_ctrl #(
    parameter logic [7:0] ID_VALUE  = 8'hA5,
    parameter int         BLINK_DIV = 25_000_000
) (
    input  logic       INPUT_CLK,
    input  logic       reset,
    input  logic       ss_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       tx_load,
    output logic [7:0] tx_byte,
    output logic [6:0] gpo_pins,
    output logic       led0,
    output logic       led1
);

    localparam int                 CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    state_t           state_q, state_d;
    logic             ss_prev_q;
    logic [6:0]       addr_q, addr_d;
    logic             tx_load_q, tx_load_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [6:0]       gpo_q, gpo_d;
    logic [2:0]       ledctl_q, ledctl_d;
    logic [7:0]       scratch_q, scratch_d;
    logic [7:0]       frames_q, frames_d;
    logic [7:0]       errs_q, errs_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_mapped;
    logic       byte_ok;
    logic       preload;
    logic       do_write;
    logic       err_inc;

    // The command byte carries the first read address; later reads fetch the next one.
    assign rd_addr   = (state_q == CMD) ? rx_byte[6:0] : addr_q + 7'd1;
    assign rd_mapped = (rd_addr <= 7'h05);
    assign byte_ok   = rx_valid && ss_active;

    always_comb begin
        case (rd_addr)
            7'h00:   rd_data = ID_VALUE;
            7'h01:   rd_data = {1'b0, gpo_q};
            7'h02:   rd_data = {5'b0, ledctl_q};
            7'h03:   rd_data = scratch_q;
            7'h04:   rd_data = frames_q;
            7'h05:   rd_data = errs_q;
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d       = state_q;
        addr_d        = addr_q;
        tx_load_d     = 1'b0;
        tx_byte_d     = tx_byte_q;
        gpo_d         = gpo_q;
        ledctl_d      = ledctl_q;
        scratch_d     = scratch_q;
        frames_d      = frames_q;
        errs_d        = errs_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        preload       = 1'b0;
        do_write      = 1'b0;
        err_inc       = 1'b0;

        case (state_q)
            IDLE: if (ss_active && !ss_prev_q) state_d = CMD;
            CMD: begin
                if (byte_ok) begin
                    addr_d  = rx_byte[6:0];
                    state_d = rx_byte[7] ? RD : WR;
                    preload = rx_byte[7];
                end
            end
            WR: begin
                if (byte_ok) begin
                    do_write = 1'b1;
                    addr_d   = addr_q + 7'd1;
                end
            end
            RD: begin
                if (byte_ok) begin
                    addr_d  = addr_q + 7'd1;
                    preload = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (preload) begin
            tx_byte_d = rd_data;
            tx_load_d = 1'b1;
            err_inc   = !rd_mapped;
        end

        if (do_write) begin
            case (addr_q)
                7'h01:               gpo_d     = rx_byte[6:0];
                7'h02:               ledctl_d  = rx_byte[2:0];
                7'h03:               scratch_d = rx_byte;
                7'h00, 7'h04, 7'h05: ;
                default:             err_inc   = 1'b1;
            endcase
        end

        if (err_inc && errs_q != 8'hFF) errs_d = errs_q + 8'd1;

        if (!ss_active) begin
            state_d   = IDLE;
            tx_byte_d = 8'h00;
            if (state_q == WR || state_q == RD) frames_d = frames_q + 8'd1;
        end

        // Clearing the enable zeroes the prescaler on the same edge as the write.
        if (!ledctl_d[2]) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (ledctl_q[2]) begin
            if (blink_cnt_q == CNT_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state updates use nonblocking assignments so every register samples pre-edge values.
    always_ff @(posedge INPUT_CLK) begin
        if (reset) begin
            state_q       <= IDLE;
            // Held high so a frame already open when reset releases is not mistaken for a new one.
            ss_prev_q     <= 1'b1;
            addr_q        <= 7'h00;
            tx_load_q     <= 1'b0;
            tx_byte_q     <= 8'h00;
            // NOTE: the register file is a handful of flops, so it resets like any other state.
            gpo_q         <= 7'h00;
            ledctl_q      <= 3'h0;
            scratch_q     <= 8'h00;
            frames_q      <= 8'h00;
            errs_q        <= 8'h00;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ss_prev_q     <= ss_active;
            addr_q        <= addr_d;
            tx_load_q     <= tx_load_d;
            tx_byte_q     <= tx_byte_d;
            gpo_q         <= gpo_d;
            ledctl_q      <= ledctl_d;
            scratch_q     <= scratch_d;
            frames_q      <= frames_d;
            errs_q        <= errs_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign tx_load  = tx_load_q;
    assign tx_byte  = tx_byte_q;
    assign gpo_pins = gpo_q;
    assign led1     = ledctl_q[1];
    assign led0     = ledctl_q[2] ? blink_phase_q : ledctl_q[0];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus random bursts
// compared against a transaction-level register-map model.
module tb_spi_reg_ctrl;

    localparam logic [7:0] ID = 8'hA5;

    logic       INPUT_CLK = 1'b0;
    logic       reset     = 1'b1;
    logic       ss_active = 1'b0;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_byte   = 8'h00;
    logic       tx_load;
    logic [7:0] tx_byte;
    logic [6:0] gpo_pins;
    logic       led0;
    logic       led1;

    spi_reg_ctrl #(.ID_VALUE(ID), .BLINK_DIV(4)) dut (
        .INPUT_CLK (INPUT_CLK),
        .reset     (reset),
        .ss_active (ss_active),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_load   (tx_load),
        .tx_byte   (tx_byte),
        .gpo_pins  (gpo_pins),
        .led0      (led0),
        .led1      (led1)
    );

    always #5 INPUT_CLK = ~INPUT_CLK;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   load_cnt    = 0;
    int   last_wr_cyc = 0;
    int   toggles[$];
    logic led0_prev   = 1'b0;
    logic [7:0] fq[$];

    // Register-map model.
    logic [6:0] m_gpo;
    logic [2:0] m_led;
    logic [7:0] m_scr, m_frames, m_errs;

    always @(posedge INPUT_CLK) cyc++;

    always @(posedge INPUT_CLK) begin
        #1;
        if (tx_load === 1'b1) load_cnt++;
        if (led0 !== led0_prev) toggles.push_back(cyc);
        led0_prev = led0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge INPUT_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_gpo = '0; m_led = '0; m_scr = '0; m_frames = '0; m_errs = '0;
    endtask

    task automatic m_access(input bit wr, input logic [6:0] a, input logic [7:0] d,
                            output logic [7:0] rd);
        rd = 8'h00;
        if (a > 7'h05) begin
            if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
        end else if (wr) begin
            if (a == 7'h01) m_gpo = d[6:0];
            else if (a == 7'h02) m_led = d[2:0];
            else if (a == 7'h03) m_scr = d;
        end else begin
            case (a)
                7'h00: rd = ID;
                7'h01: rd = {1'b0, m_gpo};
                7'h02: rd = {5'b0, m_led};
                7'h03: rd = m_scr;
                7'h04: rd = m_frames;
                default: rd = m_errs;
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_gpo"}, gpo_pins, m_gpo);
        check({tag, "_led1"}, led1, m_led[1]);
        if (!m_led[2]) check({tag, "_led0"}, led0, m_led[0]);
    endtask

    // Runs one frame from fq; optionally drops ss_active together with the last byte.
    task automatic run_frame(input bit abort_last);
        int n, loads0, exp_loads, g;
        bit rd, reached, aborted;
        logic [6:0] a;
        logic [7:0] exp, dummy;
        n = fq.size(); loads0 = load_cnt; exp_loads = 0;
        rd = 0; reached = 0; aborted = 0; a = 0; exp = 0;
        ss_active = 1'b1;
        tick(); tick();
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_byte  = fq[i];
            if (abort_last && i == n - 1) begin
                ss_active = 1'b0;
                aborted   = 1;
            end
            tick();
            rx_valid = 1'b0;
            if (aborted) begin
                check("abort_tx_load", tx_load, 0);
                check("abort_tx_byte", tx_byte, 8'h00);
                check_outputs("abort");
                break;
            end
            if (i == 0) begin
                rd = fq[0][7]; a = fq[0][6:0]; reached = 1;
            end else if (rd) begin
                a = a + 7'd1;
            end
            if (rd) begin
                m_access(0, a, 8'h00, exp);
                exp_loads++;
                check("rd_tx_load", tx_load, 1);
                check("rd_tx_byte", tx_byte, exp);
            end else begin
                if (i > 0) begin
                    m_access(1, a, fq[i], dummy);
                    a = a + 7'd1;
                    last_wr_cyc = cyc;
                end
                check("wr_tx_load", tx_load, 0);
                check("wr_tx_byte", tx_byte, 8'h00);
                check_outputs("wr");
            end
            g = $urandom_range(0, 2);
            repeat (g) begin
                tick();
                check("gap_tx_load", tx_load, 0);
                check("gap_tx_byte", tx_byte, rd ? exp : 8'h00);
            end
        end
        if (!aborted) begin
            ss_active = 1'b0;
            tick();
        end
        if (reached) m_frames = m_frames + 8'd1;
        tick();
        check("idle_tx_byte", tx_byte, 8'h00);
        check("frame_loads", load_cnt - loads0, exp_loads);
        check_outputs("frame_end");
    endtask

    initial begin
        int n;
        m_reset();
        repeat (3) tick();
        check("rst_tx_load", tx_load, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_gpo", gpo_pins, 7'h00);
        check("rst_led0", led0, 0);
        check("rst_led1", led1, 0);
        reset = 1'b0;
        tick(); tick();

        // Whole register map after reset.
        fq = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(0);

        // Plain write to GPO.
        fq = '{8'h01, 8'h55};
        run_frame(0);
        check("t1_gpo_literal", gpo_pins, 7'h55);

        // Read burst ID, GPO, LEDCTL.
        fq = '{8'h80, 8'h00, 8'h00};
        run_frame(0);

        // Write burst from the top of the address space wraps into read-only ID.
        fq = '{8'h7F, 8'h11, 8'h22};
        run_frame(0);
        fq = '{8'h85};
        run_frame(0);
        fq = '{8'h80};
        run_frame(0);

        // Byte coinciding with ss_active falling is discarded.
        fq = '{8'h03, 8'h99};
        run_frame(1);
        fq = '{8'h83, 8'h00, 8'h00};
        run_frame(0);

        // Empty frame does not count; an aborted command byte does not count either.
        fq = {};
        run_frame(0);
        fq = '{8'h84};
        run_frame(1);
        fq = '{8'h84};
        run_frame(0);

        // Blink with BLINK_DIV=4.
        toggles.delete();
        fq = '{8'h02, 8'h04};
        run_frame(0);
        repeat (14) tick();
        check("blink_count_ok", toggles.size() >= 3, 1);
        if (toggles.size() >= 3) begin
            check("blink_first", toggles[0] - last_wr_cyc, 4);
            check("blink_period1", toggles[1] - toggles[0], 4);
            check("blink_period2", toggles[2] - toggles[1], 4);
        end
        fq = '{8'h02, 8'h01};
        run_frame(0);
        check("blink_off_led0", led0, 1);
        fq = '{8'h02, 8'h00};
        run_frame(0);
        toggles.delete();
        fq = '{8'h02, 8'h04};
        run_frame(0);
        repeat (8) tick();
        check("blink_restart_ok", toggles.size() >= 1, 1);
        if (toggles.size() >= 1) check("blink_restart", toggles[0] - last_wr_cyc, 4);
        fq = '{8'h02, 8'h00};
        run_frame(0);

        // Random bursts.
        repeat (40) begin
            logic [6:0] a0;
            a0 = ($urandom_range(0, 3) < 3) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(8'h7C, 8'h7F));
            n  = $urandom_range(0, 5);
            fq = {};
            fq.push_back({1'($urandom_range(0, 1)), a0});
            repeat (n) fq.push_back(8'($urandom));
            run_frame($urandom_range(0, 7) == 0);
        end
        fq = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(0);

        // Reset in the middle of a write burst.
        ss_active = 1'b1;
        tick(); tick();
        rx_valid = 1'b1; rx_byte = 8'h01; tick(); rx_valid = 1'b0;
        rx_valid = 1'b1; rx_byte = 8'h2A; tick(); rx_valid = 1'b0;
        check("t6_pre_gpo", gpo_pins, 7'h2A);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        check("t6_tx_load", tx_load, 0);
        check("t6_tx_byte", tx_byte, 8'h00);
        check("t6_gpo", gpo_pins, 7'h00);
        check("t6_led0", led0, 0);
        check("t6_led1", led1, 0);
        fq = '{8'h01, 8'h33, 8'h44};
        foreach (fq[i]) begin
            rx_valid = 1'b1; rx_byte = fq[i]; tick(); rx_valid = 1'b0;
            check("t6_ignored_gpo", gpo_pins, 7'h00);
            check("t6_ignored_load", tx_load, 0);
        end
        ss_active = 1'b0;
        tick(); tick();
        fq = '{8'h84, 8'h00};
        run_frame(0);
        fq = '{8'h01, 8'h12};
        run_frame(0);
        check("t6_after_gpo", gpo_pins, 7'h12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
